// File: rtl/fact_pkg.sv
// rtl/fact_pkg.sv - shared types and constants for the iterative factorial engine
//
// Purpose: FSM state encoding, default widths, and the saturation fill value
//          used on overflow when the FACT_SAT_EN build is selected.
// Ports:   none (package)

package fact_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } factState_t;

  localparam int N_WIDTH_DEF   = 4;
  localparam int RES_WIDTH_DEF = 32;

  // All-ones value of width w, right-aligned in a 128-bit container.
  // Callers slice the low w bits; result widths beyond 128 are not supported.
  function automatic logic [127:0] ovfSatValue(input int w);
    logic [127:0] ones;
    ones = {128{1'b1}};
    return ones >> (128 - w);
  endfunction

endpackage

// File: rtl/fact_mul_chk.sv
// rtl/fact_mul_chk.sv - combinational multiply with overflow detect
//
// Purpose: full-width RES_WIDTH x RES_WIDTH multiply; returns the low half and
//          flags any nonzero bit in the upper half.
// Ports:   a, b    in  RES_WIDTH  operands
//          prodLo  out RES_WIDTH  low half of a*b
//          ovf     out 1          upper half of a*b is nonzero

module fact_mul_chk
  import fact_pkg::*;
#(
  parameter int RES_WIDTH = RES_WIDTH_DEF
) (
  input  logic [RES_WIDTH-1:0] a,
  input  logic [RES_WIDTH-1:0] b,
  output logic [RES_WIDTH-1:0] prodLo,
  output logic                 ovf
);

  logic [2*RES_WIDTH-1:0] full;

  // Zero-extend both operands so the product is computed at double width.
  assign full   = {{RES_WIDTH{1'b0}}, a} * {{RES_WIDTH{1'b0}}, b};
  assign prodLo = full[RES_WIDTH-1:0];
  assign ovf    = |full[2*RES_WIDTH-1:RES_WIDTH];

endmodule

// File: rtl/fact_engine_n.sv
// rtl/fact_engine_n.sv - parametrised iterative factorial engine with go/done handshake
//
// Purpose: computes n! one multiply per cycle, aborting on the first multiply
//          whose product does not fit in RES_WIDTH bits.
// Build option: FACT_SAT_EN - when defined, an overflowed result reads as all
//          ones; otherwise it reads as 0. err is set in both builds.
// Ports:   clk     in  1          system clock
//          rst     in  1          asynchronous active-low reset
//          go      in  1          start request, honoured only in IDLE
//          n       in  N_WIDTH    operand, latched when go is accepted
//          busy    out 1          computation in progress
//          done    out 1          one-cycle pulse when result/err are valid
//          result  out RES_WIDTH  n! or overflow value
//          err     out 1          overflow flag

module fact_engine_n
  import fact_pkg::*;
#(
  parameter int N_WIDTH   = N_WIDTH_DEF,
  parameter int RES_WIDTH = RES_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [N_WIDTH-1:0]   n,
  output logic                 busy,
  output logic                 done,
  output logic [RES_WIDTH-1:0] result,
  output logic                 err
);

`ifdef FACT_SAT_EN
  localparam logic [127:0]         OVF_FULL   = ovfSatValue(RES_WIDTH);
  localparam logic [RES_WIDTH-1:0] OVF_RESULT = OVF_FULL[RES_WIDTH-1:0];
`else
  localparam logic [RES_WIDTH-1:0] OVF_RESULT = '0;
`endif

  factState_t           state, stateNext;
  logic [N_WIDTH-1:0]   cnt, cntNext;
  logic [RES_WIDTH-1:0] prod, prodNext;
  logic                 errInt, errIntNext;
  logic                 busyNext, doneNext, errNext;
  logic [RES_WIDTH-1:0] resultNext;

  logic [RES_WIDTH-1:0] mulLo;
  logic                 mulOvf;

  fact_mul_chk #(
    .RES_WIDTH(RES_WIDTH)
  ) uMul (
    .a      (prod),
    .b      (RES_WIDTH'(cnt)),
    .prodLo (mulLo),
    .ovf    (mulOvf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      prod   <= '0;
      errInt <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      prod   <= prodNext;
      errInt <= errIntNext;
      busy   <= busyNext;
      done   <= doneNext;
      result <= resultNext;
      err    <= errNext;
    end
  end

  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    prodNext   = prod;
    errIntNext = errInt;
    busyNext   = busy;
    doneNext   = 1'b0;
    resultNext = result;
    errNext    = err;

    case (state)
      IDLE: begin
        if (go) begin
          cntNext    = n;
          prodNext   = RES_WIDTH'(1);
          errIntNext = 1'b0;
          busyNext   = 1'b1;
          resultNext = '0;
          errNext    = 1'b0;
          stateNext  = MULT;
        end
      end
      MULT: begin
        if (cnt <= N_WIDTH'(1)) begin
          stateNext = DONE;
        end else if (mulOvf) begin
          // Abort on the first overflowing multiply; prod is left stale.
          errIntNext = 1'b1;
          stateNext  = DONE;
        end else begin
          prodNext = mulLo;
          cntNext  = cnt - N_WIDTH'(1);
        end
      end
      DONE: begin
        resultNext = errInt ? OVF_RESULT : prod;
        errNext    = errInt;
        doneNext   = 1'b1;
        busyNext   = 1'b0;
        stateNext  = IDLE;
      end
      default: begin
        stateNext = IDLE;
        busyNext  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fact_engine_n.sv
// tb/tb_fact_engine_n.sv - self-checking bench for fact_engine_n (default and 5/64 builds)

module tb_fact_engine_n;

  logic        clk;
  logic        rst;

  logic        goA;
  logic [3:0]  nA;
  logic        busyA, doneA, errA;
  logic [31:0] resA;

  logic        goB;
  logic [4:0]  nB;
  logic        busyB, doneB, errB;
  logic [63:0] resB;

  int checks;
  int errors;

`ifdef FACT_SAT_EN
  localparam logic [63:0] OVF_A = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] OVF_B = 64'hFFFF_FFFF_FFFF_FFFF;
`else
  localparam logic [63:0] OVF_A = 64'd0;
  localparam logic [63:0] OVF_B = 64'd0;
`endif

  fact_engine_n uDutA (
    .clk    (clk),
    .rst    (rst),
    .go     (goA),
    .n      (nA),
    .busy   (busyA),
    .done   (doneA),
    .result (resA),
    .err    (errA)
  );

  fact_engine_n #(
    .N_WIDTH   (5),
    .RES_WIDTH (64)
  ) uDutB (
    .clk    (clk),
    .rst    (rst),
    .go     (goB),
    .n      (nB),
    .busy   (busyB),
    .done   (doneB),
    .result (resB),
    .err    (errB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wide;
    logic [4:0]  n;
    logic [63:0] expRes;
    logic        expErr;
    int          expLat;
  } vec_t;

  vec_t vecs[11];

  function automatic logic curBusy(input bit wide);
    return wide ? busyB : busyA;
  endfunction

  function automatic logic curDone(input bit wide);
    return wide ? doneB : doneA;
  endfunction

  function automatic logic curErr(input bit wide);
    return wide ? errB : errA;
  endfunction

  function automatic logic [63:0] curRes(input bit wide);
    return wide ? resB : {32'd0, resA};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Counts edges after the accept edge until done is seen, sampling 1ns after each edge.
  task automatic waitDone(input bit wide, output int lat);
    lat = 0;
    while (!curDone(wide) && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!curDone(wide)) chk("done_timeout", 64'(lat), 64'd0);
  endtask

  task automatic runCalc(input bit wide, input logic [4:0] nv, input bit holdGo,
                         output int lat, output logic [63:0] res, output logic e);
    @(negedge clk);
    if (wide) begin goB = 1'b1; nB = nv; end
    else      begin goA = 1'b1; nA = nv[3:0]; end
    @(posedge clk);
    #1;
    if (!holdGo) begin goA = 1'b0; goB = 1'b0; end
    chk("busy_on_accept", 64'(curBusy(wide)), 64'd1);
    chk("result_cleared", curRes(wide), 64'd0);
    chk("err_cleared", 64'(curErr(wide)), 64'd0);
    waitDone(wide, lat);
    res = curRes(wide);
    e   = curErr(wide);
  endtask

  initial begin
    int          lat;
    logic [63:0] res;
    logic        e;

    checks = 0;
    errors = 0;
    goA = 1'b0; nA = '0;
    goB = 1'b0; nB = '0;

    vecs[0]  = '{1'b0, 5'd5,  64'd120,                  1'b0, 6};
    vecs[1]  = '{1'b0, 5'd3,  64'd6,                    1'b0, 4};
    vecs[2]  = '{1'b0, 5'd0,  64'd1,                    1'b0, 2};
    vecs[3]  = '{1'b0, 5'd1,  64'd1,                    1'b0, 2};
    vecs[4]  = '{1'b0, 5'd12, 64'd479001600,            1'b0, 13};
    vecs[5]  = '{1'b0, 5'd13, OVF_A,                    1'b1, 13};
    vecs[6]  = '{1'b0, 5'd2,  64'd2,                    1'b0, 3};
    vecs[7]  = '{1'b0, 5'd15, OVF_A,                    1'b1, 11};
    vecs[8]  = '{1'b1, 5'd20, 64'd2432902008176640000,  1'b0, 21};
    vecs[9]  = '{1'b1, 5'd21, OVF_B,                    1'b1, 20};
    vecs[10] = '{1'b1, 5'd4,  64'd24,                   1'b0, 5};

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy",   64'(busyA), 64'd0);
    chk("reset_done",   64'(doneA), 64'd0);
    chk("reset_result", {32'd0, resA}, 64'd0);
    chk("reset_err",    64'(errA), 64'd0);
    chk("reset_result_wide", resB, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      runCalc(vecs[i].wide, vecs[i].n, 1'b0, lat, res, e);
      chk($sformatf("vec%0d_result", i), res, vecs[i].expRes);
      chk($sformatf("vec%0d_err", i), 64'(e), 64'(vecs[i].expErr));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].expLat));
      chk($sformatf("vec%0d_busy_at_done", i), 64'(curBusy(vecs[i].wide)), 64'd0);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_done_one_cycle", i), 64'(curDone(vecs[i].wide)), 64'd0);
      chk($sformatf("vec%0d_result_held", i), curRes(vecs[i].wide), vecs[i].expRes);
    end

    // go re-asserted with a different n while busy must be ignored
    @(negedge clk);
    goA = 1'b1; nA = 4'd7;
    @(posedge clk);
    #1;
    goA = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    goA = 1'b1; nA = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    goA = 1'b0;
    lat = 4;
    begin
      int more;
      waitDone(1'b0, more);
      lat = lat + more;
    end
    chk("busy_go_result", {32'd0, resA}, 64'd5040);
    chk("busy_go_latency", 64'(lat), 64'd8);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_go_not_queued", 64'(busyA), 64'd0);

    // go held high: back-to-back runs with one idle cycle between
    runCalc(1'b0, 5'd3, 1'b1, lat, res, e);
    chk("hold_first_result", res, 64'd6);
    chk("hold_first_latency", 64'(lat), 64'd4);
    @(posedge clk);
    #1;
    nA = 4'd4;
    chk("hold_restart_busy", 64'(busyA), 64'd1);
    chk("hold_restart_done_low", 64'(doneA), 64'd0);
    chk("hold_restart_cleared", {32'd0, resA}, 64'd0);
    goA = 1'b0;
    waitDone(1'b0, lat);
    chk("hold_second_result", {32'd0, resA}, 64'd6);
    chk("hold_second_latency", 64'(lat), 64'd4);
    repeat (2) @(posedge clk);

    // asynchronous reset in the middle of MULT
    @(negedge clk);
    goA = 1'b1; nA = 4'd10;
    @(posedge clk);
    #1;
    goA = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("midrst_busy_before", 64'(busyA), 64'd1);
    rst = 1'b0;
    #1;
    chk("midrst_busy",   64'(busyA), 64'd0);
    chk("midrst_done",   64'(doneA), 64'd0);
    chk("midrst_result", {32'd0, resA}, 64'd0);
    chk("midrst_err",    64'(errA), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    begin
      int seenDone;
      seenDone = 0;
      for (int c = 0; c < 12; c++) begin
        @(posedge clk);
        #1;
        if (doneA) seenDone++;
      end
      chk("midrst_no_done", 64'(seenDone), 64'd0);
    end
    runCalc(1'b0, 5'd4, 1'b0, lat, res, e);
    chk("after_rst_result", res, 64'd24);
    chk("after_rst_err", 64'(e), 64'd0);
    chk("after_rst_latency", 64'(lat), 64'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
